reg_mem_unit: RTL and testbench

Parametrised register file with an integrated load/store sequencer. It replaces the fixed 32-bit, single-write-port register/RAM pairing in the CPU datapath. The unit accepts one operation at a time over a valid/ready handshake: move-immediate, load, or store. It drives a synchronous RAM with a configurable read latency and writes load results back into the register file. It sits between instruction decode (upstream) and the data RAM (downstream).

---
 rtl/reg_mem_unit.sv | 126 ++++++++++++
 tb/tb_reg_mem_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mem_unit.sv
// Register file with a load/store sequencer in front of a synchronous RAM.
// It accepts one operation at a time: move-immediate, load or store.
module reg_mem_unit #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_kind,
  input  logic [RW-1:0]     rd,
  input  logic [RW-1:0]     ra,
  input  logic [DATA_W-1:0] imm,
  input  logic [RW-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_val,
  output logic [DATA_W-1:0] r0_value,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ldr,
  output logic              mem_str,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [RW-1:0]       rd_q;
  logic [2:0]          cnt_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_ldr_q;
  logic                mem_str_q;
  logic                done_q;
  logic                err_q;

  // Sequencer, register file and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      cnt_q       <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ldr_q   <= 1'b0;
      mem_str_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // Strobes and done are single-cycle pulses unless re-asserted below.
      mem_ldr_q <= 1'b0;
      mem_str_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            case (op_kind)
              2'b00: begin
                regs_q[rd] <= imm;
                done_q     <= 1'b1;
              end
              2'b01: begin
                mem_addr_q <= regs_q[ra][ADDR_W-1:0];
                rd_q       <= rd;
                cnt_q      <= 3'(MEM_LAT);
                mem_ldr_q  <= 1'b1;
                state_q    <= S_LOAD;
              end
              2'b10: begin
                mem_addr_q  <= regs_q[ra][ADDR_W-1:0];
                mem_wdata_q <= regs_q[rd];
                mem_str_q   <= 1'b1;
                state_q     <= S_STORE;
              end
              default: begin
                err_q  <= 1'b1;
                done_q <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD: begin
          // Read data is valid in the cycle where the countdown reaches zero.
          if (cnt_q == 3'd0) begin
            regs_q[rd_q] <= mem_rdata;
            done_q       <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_STORE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign op_ready  = (state_q == S_IDLE);
  assign dbg_val   = regs_q[dbg_sel];
  assign r0_value  = regs_q[0];
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_ldr   = mem_ldr_q;
  assign mem_str   = mem_str_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_mem_unit.sv
// Directed bench: a 32-bit/16-reg unit with 3-cycle RAM and a 16-bit/4-reg unit with 1-cycle RAM.
module tb_reg_mem_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance: DATA_W=32, NREGS=16, MEM_LAT=3
  logic        op_valid = 1'b0, op_ready, mem_ldr, mem_str, done, err;
  logic [1:0]  op_kind = 2'b00;
  logic [3:0]  rd = 4'd0, ra = 4'd0, dbg_sel = 4'd0;
  logic [31:0] imm = 32'd0, dbg_val, r0_value, mem_addr, mem_wdata, mem_rdata;

  reg_mem_unit #(.DATA_W(32), .NREGS(16), .ADDR_W(32), .MEM_LAT(3)) u_dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
    .rd(rd), .ra(ra), .imm(imm), .dbg_sel(dbg_sel), .dbg_val(dbg_val), .r0_value(r0_value),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ldr(mem_ldr), .mem_str(mem_str),
    .mem_rdata(mem_rdata), .done(done), .err(err)
  );

  // Small instance: DATA_W=16, NREGS=4, MEM_LAT=1
  logic        s_op_valid = 1'b0, s_op_ready, s_mem_ldr, s_mem_str, s_done, s_err;
  logic [1:0]  s_op_kind = 2'b00, s_rd = 2'd0, s_ra = 2'd0, s_dbg_sel = 2'd0;
  logic [15:0] s_imm = 16'd0, s_dbg_val, s_r0_value, s_mem_addr, s_mem_wdata;
  logic [15:0] s_mem_rdata = 16'h5A5A;

  reg_mem_unit #(.DATA_W(16), .NREGS(4), .ADDR_W(16), .MEM_LAT(1)) u_small (
    .clk(clk), .rst(rst), .op_valid(s_op_valid), .op_ready(s_op_ready), .op_kind(s_op_kind),
    .rd(s_rd), .ra(s_ra), .imm(s_imm), .dbg_sel(s_dbg_sel), .dbg_val(s_dbg_val),
    .r0_value(s_r0_value), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_ldr(s_mem_ldr), .mem_str(s_mem_str), .mem_rdata(s_mem_rdata), .done(s_done), .err(s_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // RAM model: data is valid only in the cycle ending MEM_LAT edges after the strobe edge.
  int          lcnt = 0;
  logic [31:0] ram_word = 32'd0;
  assign mem_rdata = (lcnt == 1) ? ram_word : 32'hBAD0BAD0;

  int          ldr_cnt = 0, str_cnt = 0, done_cnt = 0;
  logic [31:0] ldr_addr = 32'd0, str_addr = 32'd0, str_data = 32'd0;
  logic [15:0] s_str_addr = 16'd0, s_str_data = 16'd0;
  int          s_str_cnt = 0;

  // Bus monitor and RAM latency counter.
  always @(posedge clk) begin
    if (mem_ldr) lcnt <= 3;
    else if (lcnt != 0) lcnt <= lcnt - 1;
    if (mem_ldr) begin ldr_cnt <= ldr_cnt + 1; ldr_addr <= mem_addr; end
    if (mem_str) begin str_cnt <= str_cnt + 1; str_addr <= mem_addr; str_data <= mem_wdata; end
    if (done) done_cnt <= done_cnt + 1;
    if (s_mem_str) begin s_str_cnt <= s_str_cnt + 1; s_str_addr <= s_mem_addr; s_str_data <= s_mem_wdata; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic peek(input logic [3:0] sel, output logic [31:0] v);
    dbg_sel = sel; #1; v = dbg_val;
  endtask

  task automatic peek_s(input logic [1:0] sel, output logic [31:0] v);
    s_dbg_sel = sel; #1; v = {16'd0, s_dbg_val};
  endtask

  // Present one op while ready, then count cycles from the accept edge to done.
  task automatic issue(input logic [1:0] k, input logic [3:0] d, input logic [3:0] a,
                       input logic [31:0] im, output int lat);
    op_valid = 1'b1; op_kind = k; rd = d; ra = a; imm = im;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic issue_s(input logic [1:0] k, input logic [1:0] d, input logic [1:0] a,
                         input logic [15:0] im, output int lat);
    s_op_valid = 1'b1; s_op_kind = k; s_rd = d; s_ra = a; s_imm = im;
    @(posedge clk); #1;
    s_op_valid = 1'b0;
    lat = 1;
    while (!s_done && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [31:0] imm;
    logic [31:0] ram;
    int          exp_lat;
    logic [3:0]  sel;
    logic [31:0] exp_val;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          dc;
    logic [31:0] v;

    tbl[0] = '{2'b00, 4'd3,  4'd0, 32'hDEADBEEF, 32'd0,        1, 4'd3,  32'hDEADBEEF};
    tbl[1] = '{2'b00, 4'd1,  4'd0, 32'h00000040, 32'd0,        1, 4'd1,  32'h00000040};
    tbl[2] = '{2'b00, 4'd2,  4'd0, 32'h00001234, 32'd0,        1, 4'd2,  32'h00001234};
    tbl[3] = '{2'b10, 4'd2,  4'd1, 32'd0,        32'd0,        2, 4'd2,  32'h00001234};
    tbl[4] = '{2'b01, 4'd5,  4'd1, 32'd0,        32'hCAFEF00D, 5, 4'd5,  32'hCAFEF00D};
    tbl[5] = '{2'b01, 4'd1,  4'd1, 32'd0,        32'h00000080, 5, 4'd1,  32'h00000080};
    tbl[6] = '{2'b00, 4'd0,  4'd0, 32'h00000011, 32'd0,        1, 4'd0,  32'h00000011};
    tbl[7] = '{2'b00, 4'd15, 4'd0, 32'hFFFFFFFF, 32'd0,        1, 4'd15, 32'hFFFFFFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    dbg_sel = 4'd7; #1;
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_r0", r0_value, 32'd0);
    chk("rst_dbg", dbg_val, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      ram_word = tbl[i].ram;
      issue(tbl[i].kind, tbl[i].rd, tbl[i].ra, tbl[i].imm, lat);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
      peek(tbl[i].sel, v);
      chk($sformatf("vec%0d_reg", i), v, tbl[i].exp_val);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
    end
    chk("r0_value", r0_value, 32'h11);
    chk("str_count", str_cnt, 1);
    chk("str_addr", str_addr, 32'h40);
    chk("str_data", str_data, 32'h1234);
    chk("ldr_count", ldr_cnt, 2);
    chk("ldr_addr_rd_eq_ra", ldr_addr, 32'h40);

    // op_valid held high with a different op during a load
    ram_word = 32'h0000600D;
    op_valid = 1'b1; op_kind = 2'b01; rd = 4'd6; ra = 4'd3;
    @(posedge clk); #1;
    op_kind = 2'b00; rd = 4'd7; imm = 32'h77;
    lat = 1;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("hold_ldr_latency", lat, 5);
    chk("hold_ready_on_done", {31'd0, op_ready}, 32'd1);
    chk("hold_ldr_addr", ldr_addr, 32'hDEADBEEF);
    peek(4'd7, v);
    chk("hold_movi_not_taken", v, 32'd0);
    peek(4'd6, v);
    chk("hold_ldr_value", v, 32'h600D);
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("hold_movi_done", {31'd0, done}, 32'd1);
    peek(4'd7, v);
    chk("hold_movi_value", v, 32'h77);

    // Reserved opcode: sticky err, no register effect
    issue(2'b11, 4'd3, 4'd3, 32'h0, lat);
    chk("rsv_latency", lat, 1);
    chk("rsv_err", {31'd0, err}, 32'd1);
    peek(4'd3, v);
    chk("rsv_r3_kept", v, 32'hDEADBEEF);
    issue(2'b00, 4'd4, 4'd0, 32'h44, lat);
    chk("rsv_err_sticky", {31'd0, err}, 32'd1);
    peek(4'd4, v);
    chk("rsv_next_movi", v, 32'h44);
    @(posedge clk); #1;
    chk("done_pulse_count", done_cnt, 12);
    chk("done_low_idle", {31'd0, done}, 32'd0);

    // Reset in the middle of a load
    ram_word = 32'h12345678;
    op_valid = 1'b1; op_kind = 2'b01; rd = 4'd8; ra = 4'd1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("midrst_ldr_before", {31'd0, mem_ldr}, 32'd1);
    dc = done_cnt;
    rst = 1'b0; #1;
    chk("midrst_ldr_drop", {31'd0, mem_ldr}, 32'd0);
    chk("midrst_ready", {31'd0, op_ready}, 32'd1);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_r0", r0_value, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    peek(4'd1, v);
    chk("midrst_r1", v, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    peek(4'd8, v);
    chk("midrst_no_writeback", v, 32'd0);
    chk("midrst_no_done", done_cnt, dc);
    chk("midrst_ready_after", {31'd0, op_ready}, 32'd1);

    // Narrow instance: NREGS=4, DATA_W=16, MEM_LAT=1
    @(posedge clk); #1;
    issue_s(2'b00, 2'd1, 2'd0, 16'h0040, lat);
    chk("s_movi_latency", lat, 1);
    issue_s(2'b00, 2'd3, 2'd0, 16'hBEEF, lat);
    issue_s(2'b10, 2'd3, 2'd1, 16'h0000, lat);
    chk("s_str_latency", lat, 2);
    chk("s_str_count", s_str_cnt, 1);
    chk("s_str_addr", {16'd0, s_str_addr}, 32'h0040);
    chk("s_str_data", {16'd0, s_str_data}, 32'hBEEF);
    issue_s(2'b01, 2'd2, 2'd1, 16'h0000, lat);
    chk("s_ldr_latency", lat, 3);
    peek_s(2'd2, v);
    chk("s_ldr_value", v, 32'h5A5A);
    issue_s(2'b00, 2'd0, 2'd0, 16'h00FF, lat);
    chk("s_r0_value", {16'd0, s_r0_value}, 32'h00FF);
    s_op_valid = 1'b1; s_op_kind = 2'b01; s_rd = 2'd0; s_ra = 2'd3;
    @(posedge clk); #1;
    s_op_valid = 1'b0;
    chk("s_midrst_ldr_before", {31'd0, s_mem_ldr}, 32'd1);
    rst = 1'b0; #1;
    chk("s_midrst_ldr_drop", {31'd0, s_mem_ldr}, 32'd0);
    chk("s_midrst_r0", {16'd0, s_r0_value}, 32'd0);
    peek_s(2'd3, v);
    chk("s_midrst_r3", v, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("s_midrst_no_writeback", {16'd0, s_r0_value}, 32'd0);
    chk("s_midrst_ready", {31'd0, s_op_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
